// File: rtl/cdc_pkg.sv
// rtl/cdc_pkg.sv - shared types and constants for the strobed cross-domain transfer
package cdc_pkg;

    typedef enum logic {
        CDC_IDLE = 1'b0,
        CDC_HOLD = 1'b1
    } cdc_tx_state_t;

    localparam int CDC_HOLD_MIN = 2;

endpackage

// File: rtl/cdc_hold_tx.sv
// rtl/cdc_hold_tx.sv - source-side hold transmitter; CDC_HOLD_TX_PENDING_EN adds a one-entry pending register
module cdc_hold_tx
    import cdc_pkg::*;
#(
    parameter int SIZE        = 1,
    parameter int HOLD_CYCLES = 8
) (
    input  logic            clka,
    input  logic            rsta,
    input  logic [SIZE-1:0] data_in,
    input  logic            load,
    input  logic            clr_overrun,
    output logic [SIZE-1:0] siga,
    output logic            tgla,
    output logic            busy,
    output logic            overrun
);

    localparam int CW = $clog2(HOLD_CYCLES);

    generate
        if (HOLD_CYCLES < CDC_HOLD_MIN || HOLD_CYCLES > 255) begin : g_bad_hold
            $error("cdc_hold_tx: HOLD_CYCLES out of range 2..255");
        end
    endgenerate

    cdc_tx_state_t   state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SIZE-1:0] siga_q, siga_d;
    logic            tgla_q, tgla_d;
    logic            busy_q, busy_d;
    logic            overrun_q, overrun_d;
    logic            launch;
    logic [SIZE-1:0] launch_word;
    logic            set_overrun;
`ifdef CDC_HOLD_TX_PENDING_EN
    logic            pend_valid_q, pend_valid_d;
    logic [SIZE-1:0] pend_data_q, pend_data_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        siga_d      = siga_q;
        tgla_d      = tgla_q;
        busy_d      = busy_q;
        launch      = 1'b0;
        launch_word = data_in;
        set_overrun = 1'b0;
`ifdef CDC_HOLD_TX_PENDING_EN
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
`endif
        case (state_q)
            CDC_IDLE: begin
                launch = load;
            end
            CDC_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                    if (load) begin
`ifdef CDC_HOLD_TX_PENDING_EN
                        set_overrun  = pend_valid_q;
                        pend_valid_d = 1'b1;
                        pend_data_d  = data_in;
`else
                        set_overrun  = 1'b1;
`endif
                    end
                end else if (load) begin
                    // Back-to-back launch takes priority over anything queued.
                    launch = 1'b1;
`ifdef CDC_HOLD_TX_PENDING_EN
                    set_overrun  = pend_valid_q;
                    pend_valid_d = 1'b0;
`endif
                end
`ifdef CDC_HOLD_TX_PENDING_EN
                else if (pend_valid_q) begin
                    launch       = 1'b1;
                    launch_word  = pend_data_q;
                    pend_valid_d = 1'b0;
                end
`endif
                else begin
                    state_d = CDC_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = CDC_IDLE;
        endcase

        if (launch) begin
            siga_d  = launch_word;
            tgla_d  = ~tgla_q;
            busy_d  = 1'b1;
            cnt_d   = CW'(HOLD_CYCLES - 1);
            state_d = CDC_HOLD;
        end

        if (set_overrun)      overrun_d = 1'b1;
        else if (clr_overrun) overrun_d = 1'b0;
        else                  overrun_d = overrun_q;
    end

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state_q   <= CDC_IDLE;
            cnt_q     <= '0;
            siga_q    <= '0;
            tgla_q    <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef CDC_HOLD_TX_PENDING_EN
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            siga_q    <= siga_d;
            tgla_q    <= tgla_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
`ifdef CDC_HOLD_TX_PENDING_EN
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
`endif
        end
    end

    assign siga    = siga_q;
    assign tgla    = tgla_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_cdc_hold_tx.sv
// tb/tb_cdc_hold_tx.sv - randomized bench for cdc_hold_tx against a cycle-count reference model
module tb_cdc_hold_tx;

    localparam int SIZE = 4;
    localparam int HOLD = 8;
`ifdef CDC_HOLD_TX_PENDING_EN
    localparam bit PEND = 1'b1;
`else
    localparam bit PEND = 1'b0;
`endif

    logic            clka = 1'b0;
    logic            rsta = 1'b1;
    logic [SIZE-1:0] data_in = '0;
    logic            load = 1'b0;
    logic            clr_overrun = 1'b0;
    logic [SIZE-1:0] siga;
    logic            tgla;
    logic            busy;
    logic            overrun;

    cdc_hold_tx #(.SIZE(SIZE), .HOLD_CYCLES(HOLD)) dut (
        .clka        (clka),
        .rsta        (rsta),
        .data_in     (data_in),
        .load        (load),
        .clr_overrun (clr_overrun),
        .siga        (siga),
        .tgla        (tgla),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clka = ~clka;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference: a word launched at edge E owns siga for edges E..E+HOLD-1.
    logic [SIZE-1:0] m_siga;
    bit              m_tgla, m_busy, m_ovr;
    int              cyc, launch_e;
    logic [SIZE-1:0] pend[$];

    task automatic model_reset();
        m_siga = '0; m_tgla = 0; m_busy = 0; m_ovr = 0;
        pend.delete();
    endtask

    task automatic model_launch(input logic [SIZE-1:0] w);
        m_siga   = w;
        m_tgla   = ~m_tgla;
        m_busy   = 1;
        launch_e = cyc + 1;
    endtask

    task automatic model_step(input bit l, input logic [SIZE-1:0] d, input bit c);
        bit set;
        set = 0;
        if (!m_busy) begin
            if (l) model_launch(d);
        end else if (cyc - launch_e == HOLD - 1) begin
            if (l) begin
                if (pend.size() != 0) set = 1;
                pend.delete();
                model_launch(d);
            end else if (pend.size() != 0) begin
                model_launch(pend.pop_front());
            end else begin
                m_busy = 0;
            end
        end else if (l) begin
            if (PEND) begin
                if (pend.size() != 0) begin
                    set = 1;
                    pend[0] = d;
                end else begin
                    pend.push_back(d);
                end
            end else begin
                set = 1;
            end
        end
        m_ovr = set || (m_ovr && !c);
        cyc++;
    endtask

    task automatic check_outputs();
        check("siga",    32'(siga),    32'(m_siga));
        check("tgla",    32'(tgla),    32'(m_tgla));
        check("busy",    32'(busy),    32'(m_busy));
        check("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    task automatic tick(input bit l, input logic [SIZE-1:0] d, input bit c);
        load = l; data_in = d; clr_overrun = c;
        model_step(l, d, c);
        @(negedge clka);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, '0, 0);
    endtask

    task automatic do_reset();
        rsta = 1'b1; load = 0; clr_overrun = 0;
        #1;
        check("rst_siga",    32'(siga),    32'd0);
        check("rst_tgla",    32'(tgla),    32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        model_reset();
        @(negedge clka);
        rsta = 1'b0;
    endtask

    initial begin
        cyc = 0; launch_e = 0;
        model_reset();
        @(negedge clka);
        do_reset();

        // single word, then idle with siga held
        tick(1, 4'h5, 0);
        idle(12);

        // back-to-back loads landing on the last hold cycle
        tick(1, 4'h1, 0); idle(7);
        tick(1, 4'h2, 0); idle(7);
        tick(1, 4'h3, 0); idle(12);

        // load during hold: queued or dropped depending on build
        tick(1, 4'hA, 0); idle(2);
        tick(1, 4'hB, 0); idle(2);
        tick(1, 4'hC, 0); idle(14);

        // clear racing a new overrun, then clear alone
        tick(1, 4'h6, 0); idle(2);
        tick(1, 4'h7, 0); idle(1);
        tick(1, 4'h8, 1); idle(1);
        tick(0, '0, 1);   idle(10);

        // reset 4 cycles into a hold with a word pending
        tick(1, 4'h9, 0); idle(1);
        tick(1, 4'hD, 0); idle(1);
        do_reset();
        idle(12);
        tick(1, 4'hE, 0); idle(10);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                @(negedge clka);
                do_reset();
            end else begin
                tick($urandom_range(0, 4) == 0, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 19) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
